ifq: RTL and testbench
======================

// Module: ifq
// PURPOSE
//  Instruction prefetch queue: the fetch-side counterpart of the decode front end. It acts as an AHB-Lite
//  read master that streams 32-bit instruction words into a small FIFO. It serves one 16-bit SH opcode
//  per decoder request. It sits between the core's branch/redirect logic and the instruction bus and
//  absorbs bus wait states so decode sees a continuous opcode stream.
// PARAMETERS
//  DEPTH  2  FIFO capacity in 32-bit words (power of 2, >=2); bounds outstanding fetch credits
// PORTS
//  clk       in   1   clock; all state updates on rising edge
//  rst       in   1   reset, asynchronous, active-high
//  flush     in   1   redirect: discard queue and in-flight beat, restart at flush_pc
//  flush_pc  in   32  redirect target byte address; bit 0 ignored
//  req       in   1   decoder consumes current opcode this cycle (ignored when ~op_v)
//  op        out  16  current opcode; halfword of head word selected by rpc[1]
//  op_v      out  1   op valid (FIFO non-empty and no flush this cycle)
//  op_err    out  1   head word carries bus error; qualified by op_v
//  op_pc     out  32  byte address of op (rpc)
//  HADDR     out  32  AHB address, word aligned ({faddr[31:2],2'b00})
//  HTRANS    out  2   IDLE=2'b00 / NONSEQ=2'b10 only
//  HSIZE     out  3   fixed 3'b010 (word)
//  HREADY    in   1   bus ready
//  HRESP     in   1   bus error response
//  HRDATA    in   32  read data
// BEHAVIOUR
//  Reset: rpc=0, faddr=0, FIFO empty, dphase=0, drop=0, halt=0; outputs op_v=0, op_err=0, HTRANS=IDLE,
//   HADDR=0, op_pc=0. Fetch starts from address 0 on the first cycle after reset.
//  Endianness: big-endian; rpc[1]==0 -> op=head[31:16], rpc[1]==1 -> op=head[15:0].
//  Issue: HTRANS=NONSEQ (combinational) when ~halt & ~flush & (cnt + dphase < DEPTH).
//   Address phase accepted when HREADY=1: faddr+=4 (wraps 0xFFFFFFFC->0), dphase<=1.
//  Data phase: completes when dphase & HREADY. Word pushed with err=HRESP unless drop=1.
//   Then dphase<=NONSEQ-accepted-this-cycle.
//  Pop: req & op_v -> rpc+=2; pop head word when old rpc[1]==1. Simultaneous push+pop keeps cnt.
//   A push into full FIFO cannot occur (credit rule).
//  Flush (priority over req/pop): FIFO cleared, rpc<=flush_pc&~1, faddr<={flush_pc[31:2],2'b00},
//   halt<=0. drop<=dphase-still-pending; drop clears when that beat completes. op_v=0 in flush cycle.
//   No NONSEQ in flush cycle.
//  Latency (zero-wait slave): flush cycle 0 -> NONSEQ cycle 1 -> HRDATA cycle 2 -> op_v cycle 3.
//   Steady state: one word per cycle until FIFO full.
//  Odd start: flush_pc[1]=1 -> first op is low half of first word; that word is popped after one req.
//  Error: AHB two-cycle ERROR (HRESP=1,HREADY=0 then HRESP=1,HREADY=1). In the first cycle the master
//   drives IDLE, and halt<=1. The word is pushed with err=1 on the completing cycle. No further fetch
//   until flush. The two halfwords of an err word both present op_err=1.
//  Wait states: HREADY=0 holds HADDR/HTRANS stable; no FIFO push.
//  rst mid-transfer: immediate return to reset state; the pending beat is dropped.
// TESTING
//  T1 reset, zero-wait slave, mem[0]=0x1111_2222, mem[4]=0x3333_4444, req=1 continuous.
//   -> op=0x1111,0x2222,0x3333,0x4444 on consecutive cycles from cycle 3; op_pc=0,2,4,6.
//  T2 req=0, DEPTH=2 -> exactly 2 NONSEQ issued, then HTRANS=IDLE; op_v=1, op=0x1111 held.
//  T3 flush_pc=0x0000_0102 while a beat is in data phase -> stale beat discarded.
//   HADDR=0x100 NONSEQ next cycle; first op = mem[0x100][15:0], op_pc=0x102.
//  T4 slave inserts 3 wait states per beat -> HADDR/HTRANS stable during waits.
//   Opcode order identical to T1; no duplicate or lost opcode.
//  T5 HRESP ERROR on address 0x8 -> op_err=1 for op_pc 0x8 and 0xA; HTRANS=IDLE thereafter.
//   Flush to 0x0 restores fetching with op_err=0.
//  T6 flush_pc=0xFFFF_FFFC -> fetches 0xFFFFFFFC then HADDR wraps to 0x0000_0000; op_pc wraps identically.

Source files
------------

// File: rtl/ifq.sv
// ---------------------------------------------------------------------------
// ifq -- instruction prefetch queue
//
// Streams 32-bit instruction words from an AHB-Lite slave into a small FIFO and
// hands the decoder one 16-bit big-endian opcode per request. Bus wait states
// are absorbed by the FIFO, and a redirect (flush) restarts fetching at a new
// program counter.
//
// Parameters
//   DEPTH     FIFO capacity in 32-bit words (power of two, >= 2)
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   flush     redirect: discard queue and in-flight beat, restart at flush_pc
//   flush_pc  redirect target byte address (bit 0 ignored)
//   req       decoder consumes the current opcode this cycle
//   op        current opcode (half of head word selected by op_pc[1])
//   op_v      op is valid
//   op_err    head word was fetched with a bus error (qualified by op_v)
//   op_pc     byte address of op
//   HADDR     AHB address, word aligned
//   HTRANS    AHB transfer type, IDLE or NONSEQ only
//   HSIZE     AHB size, always word
//   HREADY    AHB ready
//   HRESP     AHB error response
//   HRDATA    AHB read data
//
// Decoder handshake: an opcode transfers on every rising edge where
// op_v && req are both high. req is ignored while op_v is low, and op/op_pc
// are held stable until that transfer happens.
// ---------------------------------------------------------------------------
module ifq #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        req,
    output logic [15:0] op,
    output logic        op_v,
    output logic        op_err,
    output logic [31:0] op_pc,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // FIFO storage (no reset needed: contents are only observed when cnt_q != 0)
    logic [31:0]   data_q [DEPTH];
    logic          err_q  [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rpc_q, rpc_d;
    logic [29:0]   fword_q, fword_d;    // fetch word address (byte address >> 2)
    logic          dphase_q, dphase_d;  // a beat is in its data phase
    logic          drop_q, drop_d;      // the pending beat belongs to a flushed stream
    logic          halt_q, halt_d;      // fetching stopped after a bus error

    logic          err_first;
    logic          beat_done;
    logic          push;
    logic          pop_op;
    logic          pop_word;
    logic          issue;
    logic          credit_ok;

    // First cycle of the two-cycle AHB ERROR response.
    assign err_first = dphase_q & HRESP & ~HREADY;
    assign beat_done = dphase_q & HREADY;
    assign push      = beat_done & ~drop_q & ~flush;

    // Every word already in the FIFO or still on the bus holds one slot, so a
    // completing beat always finds room.
    assign credit_ok = ({1'b0, cnt_q} + (CW+1)'(dphase_q)) < (CW+1)'(DEPTH);

    // Address phase goes IDLE during reset, flush, halt and the first error cycle.
    assign issue    = ~rst & ~halt_q & ~flush & ~err_first & credit_ok;

    assign pop_op   = req & op_v;
    assign pop_word = pop_op & rpc_q[1];

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            rpc_q    <= '0;
            fword_q  <= '0;
            dphase_q <= 1'b0;
            drop_q   <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            rpc_q    <= rpc_d;
            fword_q  <= fword_d;
            dphase_q <= dphase_d;
            drop_q   <= drop_d;
            halt_q   <= halt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wptr_q] <= HRDATA;
            err_q[wptr_q]  <= HRESP;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        rpc_d    = rpc_q;
        fword_d  = fword_q;
        dphase_d = dphase_q;
        drop_d   = drop_q;
        halt_d   = halt_q;

        // HREADY ends the current data phase and accepts the current address
        // phase in the same cycle.
        if (HREADY) begin
            dphase_d = issue;
        end
        if (issue & HREADY) begin
            fword_d = fword_q + 30'd1;
        end
        if (beat_done) begin
            drop_d = 1'b0;
        end
        // An error on a discarded beat must not stop the new stream.
        if (err_first & ~drop_q) begin
            halt_d = 1'b1;
        end

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
            rpc_d   = flush_pc & ~32'd1;
            fword_d = flush_pc[31:2];
            halt_d  = 1'b0;
            // A beat still waiting on the bus will complete later and must be
            // discarded; one completing right now is simply not pushed.
            drop_d  = dphase_q & ~HREADY;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop_op) begin
                rpc_d = rpc_q + 32'd2;
            end
            if (pop_word) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({push, pop_word})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        op_v   = (cnt_q != '0) & ~flush;
        // Big-endian: the even halfword is the upper half of the word.
        op     = rpc_q[1] ? data_q[rptr_q][15:0] : data_q[rptr_q][31:16];
        op_err = op_v & err_q[rptr_q];
        op_pc  = rpc_q;
        HADDR  = {fword_q, 2'b00};
        HTRANS = issue ? 2'b10 : 2'b00;
        HSIZE  = 3'b010;
    end

endmodule

// File: tb/tb_ifq.sv
module tb_ifq;
  localparam int DEPTH = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush, req;
  logic [31:0] flush_pc;
  logic [15:0] op;
  logic        op_v, op_err;
  logic [31:0] op_pc, HADDR, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADY, HRESP;

  ifq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .req(req),
    .op(op), .op_v(op_v), .op_err(op_err), .op_pc(op_pc),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check_eq(input logic [31:0] act, input logic [31:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- memory / slave
  int          max_wait = 0;
  bit          rand_wait = 0;
  bit          err_single = 0;
  bit          err_hash = 0;
  logic [31:0] err_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'h0000_0000: return 32'h1111_2222;
      32'h0000_0004: return 32'h3333_4444;
      32'h0000_0008: return 32'h5555_6666;
      32'h0000_000C: return 32'h7777_8888;
      32'h0000_0100: return 32'hAAAA_BBBB;
      32'h0000_0104: return 32'hCCCC_DDDD;
      32'hFFFF_FFFC: return 32'h9999_EEEE;
      default:       return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endcase
  endfunction

  function automatic logic is_err(input logic [31:0] a, input bit es, input bit eh,
                                  input logic [31:0] ea);
    return (es && (a[31:2] == ea[31:2])) || (eh && (a[7:2] == 6'd20));
  endfunction

  logic        s_pend, s_err1;
  logic [31:0] s_addr;
  int          s_wait;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = mem_word(s_addr);
    if (s_pend) begin
      if (s_wait > 0) HREADY = 1'b0;
      else if (is_err(s_addr, err_single, err_hash, err_addr)) begin
        HRESP  = 1'b1;
        HREADY = s_err1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pend <= 1'b0; s_err1 <= 1'b0; s_wait <= 0; s_addr <= 32'h0;
    end else begin
      if (s_pend && !HREADY) begin
        if (s_wait > 0) s_wait <= s_wait - 1;
        else s_err1 <= 1'b1;
      end
      if (HREADY) begin
        s_pend <= (HTRANS == 2'b10);
        if (HTRANS == 2'b10) begin
          s_addr <= HADDR;
          s_err1 <= 1'b0;
          s_wait <= rand_wait ? int'($urandom_range(0, max_wait)) : max_wait;
        end
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard / monitor
  typedef struct {
    logic [15:0] op;
    logic [31:0] pc;
    logic        err;
    int          cyc;
  } got_t;

  got_t        got_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];   // expected-PC history for the reference stream
  bit          model_en = 0;
  bit          halted = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] m_w;
  int          n_model_ops = 0;
  int          last_flush_cyc = 0;
  logic [1:0]  prev_htrans;
  logic [31:0] prev_haddr;
  logic        prev_hready;
  bit          prev_ok = 0;
  got_t        g;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      prev_ok = 0;
    end else begin
      check_eq({30'h0, HADDR[1:0]}, 32'h0, "haddr_aligned");
      if (prev_ok && !prev_hready && prev_htrans == 2'b10 && !flush && !HRESP) begin
        check_eq({HTRANS, HADDR}, {2'b10, prev_haddr}, "wait_stable");
      end
      if (HTRANS == 2'b10 && HREADY) acc_q.push_back(HADDR);
      if (flush) begin
        check_eq({31'h0, op_v}, 32'h0, "flush_opv");
        exp_pc = flush_pc & ~32'd1;
        halted = 0;
        last_flush_cyc = cyc;
      end else if (op_v) begin
        if (model_en && halted) check_eq({31'h0, op_v}, 32'h0, "halt_opv");
        if (req) begin
          g.op = op; g.pc = op_pc; g.err = op_err; g.cyc = cyc;
          got_q.push_back(g);
          if (model_en && !halted) begin
            exp_q.push_back(exp_pc);
            m_w = mem_word(exp_pc);
            check_eq(op_pc, exp_pc, "model_pc");
            check_eq({31'h0, op_err}, {31'h0, is_err(exp_pc, err_single, err_hash, err_addr)}, "model_err");
            if (!is_err(exp_pc, err_single, err_hash, err_addr))
              check_eq({16'h0, op}, {16'h0, exp_pc[1] ? m_w[15:0] : m_w[31:16]}, "model_op");
            else if (exp_pc[1])
              halted = 1;
            exp_pc = exp_pc + 32'd2;
            n_model_ops++;
          end
        end
      end
      prev_htrans = HTRANS; prev_haddr = HADDR; prev_hready = HREADY; prev_ok = 1;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush = 1'b1;
    flush_pc = pc;
    got_q.delete();
    next_cycle();
    flush = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      next_cycle();
      k++;
    end
    check_eq(32'(got_q.size()) >= 32'(n) ? 32'(n) : 32'(got_q.size()), 32'(n), name);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic [31:0] pc;
    int          waits;
    bit          chk_lat;
    logic [15:0] ops[3];
    logic [31:0] pcs[3];
  } vec_t;

  vec_t vecs[6];

  task automatic set_vec(input int i, input logic [31:0] pc, input int w, input bit lat,
                         input logic [15:0] o0, input logic [15:0] o1, input logic [15:0] o2,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
    vecs[i].pc = pc; vecs[i].waits = w; vecs[i].chk_lat = lat;
    vecs[i].ops[0] = o0; vecs[i].ops[1] = o1; vecs[i].ops[2] = o2;
    vecs[i].pcs[0] = p0; vecs[i].pcs[1] = p1; vecs[i].pcs[2] = p2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  int rel_cyc;
  logic [31:0] rpc;

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; req = 1'b0;

    set_vec(0, 32'h0000_0000, 0, 1, 16'h1111, 16'h2222, 16'h3333, 32'h0, 32'h2, 32'h4);
    set_vec(1, 32'h0000_0102, 0, 1, 16'hBBBB, 16'hCCCC, 16'hDDDD, 32'h102, 32'h104, 32'h106);
    set_vec(2, 32'h0000_0000, 3, 0, 16'h1111, 16'h2222, 16'h3333, 32'h0, 32'h2, 32'h4);
    set_vec(3, 32'hFFFF_FFFC, 1, 0, 16'h9999, 16'hEEEE, 16'h1111, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0);
    set_vec(4, 32'h0000_0006, 2, 0, 16'h4444, 16'h5555, 16'h6666, 32'h6, 32'h8, 32'hA);
    set_vec(5, 32'h0000_000D, 0, 0, 16'h7777, 16'h8888, 16'h5A4A, 32'hC, 32'hE, 32'h10);

    // Reset state
    repeat (3) @(posedge clk);
    #4;
    check_eq({30'h0, HTRANS}, 32'h0, "rst_htrans");
    check_eq(HADDR, 32'h0, "rst_haddr");
    check_eq(op_pc, 32'h0, "rst_op_pc");
    check_eq({31'h0, op_v}, 32'h0, "rst_op_v");
    check_eq({31'h0, op_err}, 32'h0, "rst_op_err");
    check_eq({29'h0, HSIZE}, 32'h2, "hsize");

    // T1: zero-wait stream from reset, continuous req
    req = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    rel_cyc = cyc + 1;
    got_q.delete(); acc_q.delete();
    wait_got(4, 40, "t1_count");
    if (got_q.size() >= 4) begin
      check_eq(32'(got_q[0].cyc), 32'(rel_cyc + 2), "t1_first_cycle");
      check_eq(32'(got_q[3].cyc), 32'(got_q[0].cyc + 3), "t1_back_to_back");
      check_eq({16'h0, got_q[0].op}, 32'h1111, "t1_op0");
      check_eq({16'h0, got_q[1].op}, 32'h2222, "t1_op1");
      check_eq({16'h0, got_q[2].op}, 32'h3333, "t1_op2");
      check_eq({16'h0, got_q[3].op}, 32'h4444, "t1_op3");
      for (int i = 0; i < 4; i++) check_eq(got_q[i].pc, 32'(2 * i), "t1_pc");
    end

    // T2: no requests -> exactly DEPTH beats, then idle with head held
    rst = 1'b1; req = 1'b0;
    next_cycle(); next_cycle();
    rst = 1'b0;
    acc_q.delete();
    repeat (12) next_cycle();
    check_eq(32'(acc_q.size()), 32'd2, "t2_beats");
    if (acc_q.size() >= 2) begin
      check_eq(acc_q[0], 32'h0, "t2_addr0");
      check_eq(acc_q[1], 32'h4, "t2_addr1");
    end
    check_eq({30'h0, HTRANS}, 32'h0, "t2_idle");
    check_eq({31'h0, op_v}, 32'h1, "t2_op_v");
    check_eq({16'h0, op}, 32'h1111, "t2_op");

    // Table: redirects under various wait states
    req = 1'b1;
    foreach (vecs[v]) begin
      max_wait = vecs[v].waits;
      do_flush(vecs[v].pc);
      wait_got(3, 60, "vec_count");
      if (got_q.size() >= 3) begin
        if (vecs[v].chk_lat) check_eq(32'(got_q[0].cyc), 32'(last_flush_cyc + 3), "vec_latency");
        for (int i = 0; i < 3; i++) begin
          check_eq({16'h0, got_q[i].op}, {16'h0, vecs[v].ops[i]}, "vec_op");
          check_eq(got_q[i].pc, vecs[v].pcs[i], "vec_pc");
          check_eq({31'h0, got_q[i].err}, 32'h0, "vec_err");
        end
      end
    end

    // T3: flush while a beat is stalled in its data phase
    req = 1'b0; max_wait = 3;
    do_flush(32'h0);
    next_cycle(); next_cycle();
    check_eq({31'h0, s_pend}, 32'h1, "t3_beat_pending");
    do_flush(32'h0000_0102);
    check_eq({HTRANS, HADDR}, {2'b10, 32'h0000_0100}, "t3_nonseq");
    req = 1'b1;
    wait_got(1, 60, "t3_count");
    if (got_q.size() >= 1) begin
      check_eq({16'h0, got_q[0].op}, 32'hBBBB, "t3_op");
      check_eq(got_q[0].pc, 32'h102, "t3_pc");
    end

    // T5: error on word 0x8
    max_wait = 0; err_single = 1; err_addr = 32'h8;
    do_flush(32'h0);
    wait_got(6, 60, "t5_count");
    if (got_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check_eq(got_q[i].pc, 32'(2 * i), "t5_pc");
        check_eq({31'h0, got_q[i].err}, (i >= 4) ? 32'h1 : 32'h0, "t5_err");
      end
    end
    acc_q.delete();
    repeat (10) next_cycle();
    check_eq(32'(acc_q.size()), 32'h0, "t5_no_fetch");
    check_eq(32'(got_q.size()), 32'd6, "t5_no_ops");
    check_eq({30'h0, HTRANS}, 32'h0, "t5_idle");
    err_single = 0;
    do_flush(32'h0);
    wait_got(1, 40, "t5_recover_count");
    if (got_q.size() >= 1) begin
      check_eq({16'h0, got_q[0].op}, 32'h1111, "t5_recover_op");
      check_eq({31'h0, got_q[0].err}, 32'h0, "t5_recover_err");
    end

    // T6: address wrap on the bus
    req = 1'b0;
    acc_q.delete();
    do_flush(32'hFFFF_FFFC);
    repeat (6) next_cycle();
    check_eq(32'(acc_q.size()), 32'd2, "t6_beats");
    if (acc_q.size() >= 2) begin
      check_eq(acc_q[0], 32'hFFFF_FFFC, "t6_addr0");
      check_eq(acc_q[1], 32'h0, "t6_addr1");
    end

    // Random: random waits, requests, redirects and sparse bus errors
    rand_wait = 1; max_wait = 2; err_hash = 1; n_model_ops = 0;
    model_en = 1;
    exp_q.delete();
    do_flush(32'h0000_0200);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0: rpc = 32'h0;
          1: rpc = 32'hFFFF_FFF0 | ($urandom & 32'hE);
          2: rpc = $urandom;
          default: rpc = 32'h100 | ($urandom & 32'hE);
        endcase
        flush = 1'b1; flush_pc = rpc;
      end else begin
        flush = 1'b0;
        req = ($urandom_range(0, 3) != 0);
      end
      next_cycle();
      if (got_q.size() > 64) got_q.delete();
    end
    flush = 1'b0; req = 1'b0;
    model_en = 0;
    check_eq(32'(n_model_ops >= 300), 32'h1, "rand_progress");
    check_eq(32'(exp_q.size()), 32'(n_model_ops), "rand_history");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
